timer_setter: RTL and testbench
===============================

TIMER_SETTER -- requirements
Module: timer_setter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per display-digit scan step (must be 1 or more).
REQ-002 SHALL have port clk, input, 1, meaning system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port btn_next, input, 1, meaning debounced single-cycle pulse that selects the next edit digit.
REQ-005 SHALL have port btn_inc, input, 1, meaning debounced single-cycle pulse that increments the selected digit.
REQ-006 SHALL have port btn_dec, input, 1, meaning debounced single-cycle pulse that decrements the selected digit (present only with the macro in REQ-025).
REQ-007 SHALL have port btn_start, input, 1, meaning debounced single-cycle pulse that starts the countdown or aborts it.
REQ-008 SHALL have port timer_zero, input, 1, meaning high when all four countdown digits equal 0.
REQ-009 SHALL have ports preset_us, preset_ds, preset_um and preset_dm, output, 4 each, meaning BCD preset digits for units of seconds, tens of seconds, units of minutes and tens of minutes.
REQ-010 SHALL have port load, output, 1, meaning one-cycle strobe that loads the preset digits into the countdown.
REQ-011 SHALL have port running, output, 1, meaning high while the countdown is active.
REQ-012 SHALL have port edit_digit, output, 2, meaning the digit being edited (0=US, 1=DS, 2=UM, 3=DM).
REQ-013 SHALL have port seletor, output, 2, meaning free-running display scan select.

Function
REQ-014 SHALL implement three states, EDIT, LOAD and RUN, with EDIT as the reset state.
REQ-015 In EDIT, btn_inc SHALL increment the selected digit with wrap-around: US and UM go 9->0; DS and DM go 5->0.
REQ-016 In EDIT, btn_next SHALL advance edit_digit 0->1->2->3->0.
REQ-017 If btn_inc and btn_next are high in the same cycle, the increment SHALL apply to the current digit and edit_digit SHALL advance in that same cycle.
REQ-018 In EDIT, btn_start SHALL have priority over btn_inc, btn_dec and btn_next in the same cycle.
REQ-019 In EDIT, btn_start SHALL go to LOAD if any preset digit is nonzero, and SHALL be ignored if all preset digits equal 0.
REQ-020 LOAD SHALL last exactly one cycle with load=1, then go to RUN; load SHALL be 0 in every other state.
REQ-021 In RUN, running SHALL be 1; timer_zero=1 SHALL go to EDIT; btn_start SHALL abort to EDIT; btn_inc, btn_dec and btn_next SHALL be ignored; timer_zero SHALL be ignored in LOAD.
REQ-022 On return to EDIT, the preset digits SHALL keep their last values and edit_digit SHALL be 0.
REQ-023 seletor SHALL increment modulo 4 every SCAN_DIV cycles in all states.

Reset
REQ-024 rst_n=0 SHALL immediately force the state to EDIT, every preset digit to 0, edit_digit to 0, load to 0, running to 0, seletor to 0 and the scan counter to 0, including when reset occurs mid-LOAD or mid-RUN.

Configuration
REQ-025 With TIMER_SETTER_DEC_EN defined, btn_dec SHALL exist and in EDIT SHALL decrement the selected digit with wrap 0->9 (US, UM) or 0->5 (DS, DM); btn_inc and btn_dec high in the same cycle SHALL leave the digit unchanged.
REQ-026 Without TIMER_SETTER_DEC_EN, the btn_dec port and all decrement logic SHALL be absent.

Verification
REQ-027 Reset, then 3 btn_inc -> preset_us=3; then btn_next and 7 btn_inc -> preset_ds=1 (wrap after 5), edit_digit=1.
REQ-028 All digits 0, btn_start -> no load pulse, state stays EDIT.
REQ-029 Preset 00:10, btn_start -> load=1 for exactly one cycle, running=1 on the next cycle; timer_zero=1 -> running=0 and preset stays 00:10.
REQ-030 In RUN, btn_start -> running=0 with no load; btn_inc in RUN -> digits unchanged.
REQ-031 SCAN_DIV=4 -> seletor sequence 0,1,2,3,0 changes every 4 cycles; rst_n low mid-RUN -> all outputs 0.
REQ-032 With TIMER_SETTER_DEC_EN, btn_dec on DS=0 -> DS=5; btn_inc and btn_dec together -> digit unchanged.

Source files
------------

// File: rtl/timer_setter.sv
// timer_setter: BCD mm:ss preset editor with load/run control and display scan.
// Ports: clk, rst_n (async low), btn_next/btn_inc/btn_start pulses,
//   btn_dec (only with TIMER_SETTER_DEC_EN), timer_zero in;
//   preset_us/ds/um/dm, load, running, edit_digit, seletor out.
// Build option: define TIMER_SETTER_DEC_EN to add btn_dec and the decrement path.
module timer_setter #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_inc,
`ifdef TIMER_SETTER_DEC_EN
  input  logic       btn_dec,
`endif
  input  logic       btn_start,
  input  logic       timer_zero,
  output logic [3:0] preset_us,
  output logic [3:0] preset_ds,
  output logic [3:0] preset_um,
  output logic [3:0] preset_dm,
  output logic       load,
  output logic       running,
  output logic [1:0] edit_digit,
  output logic [1:0] seletor
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_EDIT,
    S_LOAD,
    S_RUN
  } state_t;

  state_t          r_state;
  logic [3:0][3:0] r_dig;
  logic [1:0]      r_edit;
  logic            r_load;
  logic            r_run;
  logic [1:0]      r_sel;
  logic [CW-1:0]   r_cnt;

  logic       w_any_set;
  logic [3:0] w_cur;
  logic [3:0] w_lim;
  logic [3:0] w_inc_val;
  logic       w_edit_en;
  logic [3:0] w_new;

  assign w_any_set = |r_dig;
  assign w_cur     = r_dig[r_edit];
  // Tens digits (DS, DM) sit at odd indices and count 0..5.
  assign w_lim     = r_edit[0] ? 4'd5 : 4'd9;
  assign w_inc_val = (w_cur >= w_lim) ? 4'd0 : w_cur + 4'd1;

`ifdef TIMER_SETTER_DEC_EN
  logic [3:0] w_dec_val;
  assign w_dec_val = (w_cur == 4'd0) ? w_lim : w_cur - 4'd1;

  // Simultaneous inc and dec cancel out.
  always_comb begin
    w_edit_en = btn_inc ^ btn_dec;
    w_new     = btn_inc ? w_inc_val : w_dec_val;
  end
`else
  always_comb begin
    w_edit_en = btn_inc;
    w_new     = w_inc_val;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EDIT;
      r_dig   <= '0;
      r_edit  <= 2'd0;
      r_load  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      unique case (r_state)
        S_EDIT: begin
          if (btn_start) begin
            if (w_any_set) begin
              r_state <= S_LOAD;
              r_load  <= 1'b1;
            end
          end else begin
            if (w_edit_en) r_dig[r_edit] <= w_new;
            if (btn_next)  r_edit <= r_edit + 2'd1;
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
          r_load  <= 1'b0;
          r_run   <= 1'b1;
        end
        S_RUN: begin
          if (btn_start || timer_zero) begin
            r_state <= S_EDIT;
            r_run   <= 1'b0;
            r_edit  <= 2'd0;
          end
        end
        default: begin
          r_state <= S_EDIT;
          r_load  <= 1'b0;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
    end else if (r_cnt == SCAN_LAST) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign preset_us  = r_dig[0];
  assign preset_ds  = r_dig[1];
  assign preset_um  = r_dig[2];
  assign preset_dm  = r_dig[3];
  assign load       = r_load;
  assign running    = r_run;
  assign edit_digit = r_edit;
  assign seletor    = r_sel;

endmodule

// File: tb/tb_timer_setter.sv
// tb_timer_setter: directed and random stimulus against a behavioural model.
// Model tracks presets, edit index, mode and cycle count since reset.
module tb_timer_setter;

  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_next = 1'b0;
  logic btn_inc = 1'b0;
  logic btn_dec = 1'b0;
  logic btn_start = 1'b0;
  logic timer_zero = 1'b0;
  logic [3:0] preset_us, preset_ds, preset_um, preset_dm;
  logic load, running;
  logic [1:0] edit_digit, seletor;

  always #5 clk = ~clk;

  timer_setter #(.SCAN_DIV(SD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_next(btn_next),
    .btn_inc(btn_inc),
`ifdef TIMER_SETTER_DEC_EN
    .btn_dec(btn_dec),
`endif
    .btn_start(btn_start),
    .timer_zero(timer_zero),
    .preset_us(preset_us),
    .preset_ds(preset_ds),
    .preset_um(preset_um),
    .preset_dm(preset_dm),
    .load(load),
    .running(running),
    .edit_digit(edit_digit),
    .seletor(seletor)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: mode 0 = edit, 1 = load, 2 = run.
  int m_p[4];
  int m_ed;
  int m_mode;
  int m_cyc;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_p[i] = 0;
    m_ed = 0;
    m_mode = 0;
    m_cyc = 0;
  endtask

  task automatic m_step(input bit nx, input bit inc, input bit dec,
                        input bit st, input bit tz);
    int lim;
    int d;
    m_cyc++;
    case (m_mode)
      0: begin
        if (st) begin
          if (m_p[0] + m_p[1] + m_p[2] + m_p[3] != 0) m_mode = 1;
        end else begin
          lim = (m_ed % 2 == 1) ? 6 : 10;
          d = 0;
          if (inc) d++;
`ifdef TIMER_SETTER_DEC_EN
          if (dec) d--;
`endif
          m_p[m_ed] = (m_p[m_ed] + d + lim) % lim;
          if (nx) m_ed = (m_ed + 1) % 4;
        end
      end
      1: m_mode = 2;
      default: begin
        if (st || tz) begin
          m_mode = 0;
          m_ed = 0;
        end
      end
    endcase
  endtask

  task automatic chk_all();
    chk("us", int'(preset_us), m_p[0]);
    chk("ds", int'(preset_ds), m_p[1]);
    chk("um", int'(preset_um), m_p[2]);
    chk("dm", int'(preset_dm), m_p[3]);
    chk("load", int'(load), int'(m_mode == 1));
    chk("running", int'(running), int'(m_mode == 2));
    chk("edit_digit", int'(edit_digit), m_ed);
    chk("seletor", int'(seletor), (m_cyc / SD) % 4);
  endtask

  // Drive at negedge, clock it in, then compare at the next negedge.
  task automatic step(input bit nx, input bit inc, input bit dec,
                      input bit st, input bit tz);
    btn_next = nx;
    btn_inc = inc;
    btn_dec = dec;
    btn_start = st;
    timer_zero = tz;
    @(posedge clk);
    m_step(nx, inc, dec, st, tz);
    @(negedge clk);
    btn_next = 0;
    btn_inc = 0;
    btn_dec = 0;
    btn_start = 0;
    timer_zero = 0;
    chk_all();
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk_all();
    @(negedge clk);
    rst_n = 1'b1;
    chk_all();
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    do_reset();

    // Three increments, then next and seven increments on DS.
    repeat (3) step(0, 1, 0, 0, 0);
    chk("d27_us", int'(preset_us), 3);
    step(1, 0, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0, 0);
    chk("d27_ds", int'(preset_ds), 1);
    chk("d27_ed", int'(edit_digit), 1);

    // Start with all zeros is ignored.
    do_reset();
    step(0, 0, 0, 1, 0);
    chk("d28_load", int'(load), 0);
    step(0, 0, 0, 0, 0);
    chk("d28_run", int'(running), 0);

    // Preset 00:10, run, then timer_zero returns to edit.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("d29_load1", int'(load), 1);
    step(0, 0, 0, 0, 1);
    chk("d29_load0", int'(load), 0);
    chk("d29_run", int'(running), 1);
    step(0, 1, 0, 0, 0);
    chk("d30_ds_run", int'(preset_ds), 1);
    step(0, 0, 0, 0, 1);
    chk("d29_stop", int'(running), 0);
    chk("d29_ds", int'(preset_ds), 1);
    chk("d29_ed", int'(edit_digit), 0);

    // Abort with start.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("d30_run", int'(running), 0);
    chk("d30_load", int'(load), 0);

    // Inc and next together.
    step(1, 1, 0, 0, 0);
    chk("d17_us", int'(preset_us), 1);
    chk("d17_ed", int'(edit_digit), 1);

`ifdef TIMER_SETTER_DEC_EN
    step(0, 0, 1, 0, 0);
    chk("d32_ds", int'(preset_ds), 0);
    step(0, 0, 1, 0, 0);
    chk("d32_wrap", int'(preset_ds), 5);
    step(0, 1, 1, 0, 0);
    chk("d32_both", int'(preset_ds), 5);
`endif

    // Reset mid-run.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("d31_pre", int'(running), 1);
    do_reset();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 11) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
